// File: rtl/series_accum_bcd_pkg.sv
// Shared constants for the series accumulator: FSM encoding, mode codes and
// active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package series_accum_bcd_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] MODE_SUM   = 2'b00;
  localparam logic [1:0] MODE_FACT  = 2'b01;
  localparam logic [1:0] MODE_SQSUM = 2'b10;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Entry d holds the pattern for decimal digit d.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low 7-segment pattern; non-decimal codes go blank.
module seg7_decode
  import series_accum_bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) seg = SEG_DIGITS[bcd];
  end

endmodule

// File: rtl/series_accum_bcd.sv
// Prescaled series accumulator (sum k, k!, sum k*k) with saturation, followed
// by a sequential double-dabble conversion onto DIGITS 7-segment displays.
module series_accum_bcd
  import series_accum_bcd_pkg::*;
#(
  parameter int N_W      = 6,
  parameter int ACC_W    = 16,
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 25_000_000
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [N_W-1:0]        num,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ACC_W-1:0]      result,
  output logic [7*DIGITS-1:0]   seg,
  output logic [1:0]            status_led
);

  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int KW      = N_W + 1;
  localparam int OPW     = ACC_W + 2*N_W;
  localparam int BCD_DIG = (ACC_W * 30103) / 100000 + 1;
  localparam int BW      = 4 * BCD_DIG;
  localparam int CW      = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  localparam int ND      = (DIGITS > BCD_DIG) ? DIGITS : BCD_DIG;

  logic [1:0]          state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [N_W-1:0]      num_q, num_d;
  logic [KW-1:0]       k_q, k_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [ACC_W-1:0]    shift_q, shift_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;

  logic                tick;
  logic [OPW-1:0]      acc_x, k_x, op_res;
  logic                op_ovf;
  logic [BW-1:0]       bcd_adj, bcd_step;
  logic [4*ND-1:0]     bcd_pad;
  logic                hi_nz, blank;
  logic [7*DIGITS-1:0] seg_nxt;

  assign tick = (state_q == S_COMPUTE) && (presc_q == PW'(TICK_DIV - 1));

  // Operands widened so products/squares never wrap before the range check.
  assign acc_x = OPW'(acc_q);
  assign k_x   = OPW'(k_q);

  always_comb begin
    case (mode_q)
      MODE_FACT:  op_res = acc_x * k_x;
      MODE_SQSUM: op_res = acc_x + k_x * k_x;
      default:    op_res = acc_x + k_x;
    endcase
  end

  assign op_ovf = |op_res[OPW-1:ACC_W];

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIG; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    bcd_step = {bcd_adj[BW-2:0], shift_q[ACC_W-1]};
  end

  always_comb begin
    bcd_pad           = '0;
    bcd_pad[BW-1:0]   = bcd_step;
    hi_nz             = 1'b0;
    for (int i = DIGITS; i < ND; i++)
      if (bcd_pad[4*i +: 4] != 4'd0) hi_nz = 1'b1;
  end

  // A bit carried out of the BCD register can only mean "not representable".
  assign blank = ovf_q | hi_nz | bcd_adj[BW-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [6:0] dseg;
    seg7_decode u_dec (
      .bcd (bcd_pad[4*g +: 4]),
      .seg (dseg)
    );
    assign seg_nxt[7*g +: 7] = blank ? SEG_DASH : dseg;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    num_d    = num_q;
    k_d      = k_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    presc_d  = presc_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    seg_d    = seg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_COMPUTE;
          mode_d  = mode;
          num_d   = num;
          k_d     = KW'(1);
          acc_d   = (mode == MODE_FACT) ? ACC_W'(1) : '0;
          ovf_d   = 1'b0;
          presc_d = '0;
        end
      end
      S_COMPUTE: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (k_q > {1'b0, num_q}) begin
            state_d = S_CONVERT;
            shift_d = acc_q;
            bcd_d   = '0;
            cnt_d   = '0;
          end else if (op_ovf) begin
            state_d = S_CONVERT;
            acc_d   = '1;
            ovf_d   = 1'b1;
            shift_d = '1;
            bcd_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = op_res[ACC_W-1:0];
            k_d   = k_q + KW'(1);
          end
        end
      end
      S_CONVERT: begin
        shift_d = {shift_q[ACC_W-2:0], 1'b0};
        bcd_d   = bcd_step;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(ACC_W - 1)) begin
          state_d  = S_DONE;
          result_d = acc_q;
          seg_d    = seg_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      num_q    <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      presc_q  <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      seg_q    <= {DIGITS{SEG_ZERO}};
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      num_q    <= num_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      presc_q  <= presc_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      seg_q    <= seg_d;
    end
  end

  assign busy       = (state_q == S_COMPUTE) || (state_q == S_CONVERT);
  assign done       = (state_q == S_DONE);
  assign overflow   = ovf_q;
  assign result     = result_q;
  assign seg        = seg_q;
  assign status_led = done ? {1'b1, ovf_q} : {1'b0, busy};

endmodule

// File: tb/tb_series_accum_bcd.sv
// Self-checking bench for series_accum_bcd (TICK_DIV=2) against an
// arithmetic reference model of the series and its decimal display.
module tb_series_accum_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [5:0]  num = 6'd0;
  logic        busy, done, overflow;
  logic [15:0] result;
  logic [27:0] seg;
  logic [1:0]  status_led;

  int checks = 0;
  int failures = 0;

  localparam logic [27:0] SEG_RST  = {4{7'b1000000}};
  localparam logic [27:0] ALL_DASH = {4{7'b0111111}};

  series_accum_bcd #(.N_W(6), .ACC_W(16), .DIGITS(4), .TICK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num(num),
    .busy(busy), .done(done), .overflow(overflow), .result(result),
    .seg(seg), .status_led(status_led)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [27:0] exp_seg(input int r, input bit ov);
    logic [27:0] s;
    int v;
    if (ov || r > 9999) return ALL_DASH;
    v = r;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[7*i +: 7] = seg_of(v % 10);
      v = v / 10;
    end
    return s;
  endfunction

  // Reference: run the series with unbounded arithmetic, saturate at 16 bits.
  task automatic model(input int m, input int n, output int r, output bit ov, output int ticks);
    longint a;
    a = (m == 1) ? 1 : 0;
    ov = 1'b0;
    ticks = n + 1;
    for (int k = 1; k <= n; k++) begin
      if (m == 1) a = a * k;
      else if (m == 2) a = a + k * k;
      else a = a + k;
      if (a > 65535) begin
        ov = 1'b1; a = 65535; ticks = k; break;
      end
    end
    r = int'(a);
  endtask

  task automatic start_run(input logic [1:0] m, input logic [5:0] n);
    @(negedge clk); start = 1'b1; mode = m; num = n;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin failures++;
      $display("FAIL reset_flags got busy=%b done=%b ovf=%b exp 0 0 0", busy, done, overflow); end
    checks++; if (result !== 16'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if (status_led !== 2'b00) begin failures++; $display("FAIL reset_led got=%b exp=00", status_led); end
    checks++; if (seg !== SEG_RST) begin failures++; $display("FAIL reset_seg got=%h exp=%h", seg, SEG_RST); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_sum10();
    int cyc;
    start_run(2'b00, 6'd10);
    checks++; if (busy !== 1'b1 || status_led !== 2'b01) begin failures++;
      $display("FAIL sum10_busy got busy=%b led=%b exp 1 01", busy, status_led); end
    wait_done(0, cyc);
    checks++; if (cyc != 38) begin failures++; $display("FAIL sum10_latency got=%0d exp=38", cyc); end
    checks++; if (result !== 16'd55) begin failures++; $display("FAIL sum10_result got=%0d exp=55", result); end
    checks++; if (seg !== exp_seg(55, 1'b0)) begin failures++; $display("FAIL sum10_seg got=%h exp=%h", seg, exp_seg(55, 1'b0)); end
    checks++; if (status_led !== 2'b10) begin failures++; $display("FAIL sum10_led got=%b exp=10", status_led); end
  endtask

  task automatic test_fact_restart();
    int cyc;
    start_run(2'b01, 6'd5);
    wait_done(0, cyc);
    checks++; if (result !== 16'd120) begin failures++; $display("FAIL fact5_result got=%0d exp=120", result); end
    start_run(2'b10, 6'd4);
    checks++; if (result !== 16'd120 || seg !== exp_seg(120, 1'b0)) begin failures++;
      $display("FAIL restart_hold got=%0d exp=120", result); end
    wait_done(0, cyc);
    checks++; if (result !== 16'd30 || overflow !== 1'b0) begin failures++;
      $display("FAIL sqsum4 got=%0d ovf=%b exp=30 ovf=0", result, overflow); end
    checks++; if (seg !== exp_seg(30, 1'b0)) begin failures++; $display("FAIL sqsum4_seg got=%h exp=%h", seg, exp_seg(30, 1'b0)); end
  endtask

  task automatic test_overflow();
    int cyc;
    start_run(2'b01, 6'd9);
    wait_done(0, cyc);
    checks++; if (overflow !== 1'b1 || result !== 16'hFFFF) begin failures++;
      $display("FAIL fact9 got=%0d ovf=%b exp=65535 ovf=1", result, overflow); end
    checks++; if (seg !== ALL_DASH) begin failures++; $display("FAIL fact9_seg got=%h exp=%h", seg, ALL_DASH); end
    checks++; if (status_led !== 2'b11) begin failures++; $display("FAIL fact9_led got=%b exp=11", status_led); end
    checks++; if (cyc != 34) begin failures++; $display("FAIL fact9_latency got=%0d exp=34", cyc); end
  endtask

  task automatic test_zero();
    int cyc;
    start_run(2'b01, 6'd0);
    wait_done(0, cyc);
    checks++; if (result !== 16'd1 || cyc != 18) begin failures++;
      $display("FAIL fact0 got=%0d cyc=%0d exp=1 cyc=18", result, cyc); end
    checks++; if (overflow !== 1'b0 || status_led !== 2'b10) begin failures++;
      $display("FAIL fact0_flags got ovf=%b led=%b exp 0 10", overflow, status_led); end
    start_run(2'b00, 6'd0);
    wait_done(0, cyc);
    checks++; if (result !== 16'd0 || seg !== SEG_RST) begin failures++;
      $display("FAIL sum0 got=%0d seg=%h exp=0 seg=%h", result, seg, SEG_RST); end
  endtask

  task automatic test_start_held();
    int cyc;
    @(negedge clk); start = 1'b1; mode = 2'b00; num = 6'd10;
    @(negedge clk); num = 6'd3;
    cyc = 0;
    repeat (10) begin @(negedge clk); cyc++; end
    start = 1'b0;
    wait_done(cyc, cyc);
    checks++; if (result !== 16'd55 || cyc != 38) begin failures++;
      $display("FAIL start_held got=%0d cyc=%0d exp=55 cyc=38", result, cyc); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_run(2'b00, 6'd10);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || status_led !== 2'b00) begin failures++;
      $display("FAIL midrst_flags got busy=%b done=%b ovf=%b led=%b", busy, done, overflow, status_led); end
    checks++; if (result !== 16'd0 || seg !== SEG_RST) begin failures++;
      $display("FAIL midrst_out got=%0d seg=%h exp=0 seg=%h", result, seg, SEG_RST); end
    @(negedge clk); rst = 1'b1;
    start_run(2'b00, 6'd3);
    wait_done(0, cyc);
    checks++; if (result !== 16'd6 || cyc != 24) begin failures++;
      $display("FAIL midrst_rerun got=%0d cyc=%0d exp=6 cyc=24", result, cyc); end
  endtask

  task automatic test_random();
    int cyc, r, ticks, m, n;
    bit ov;
    for (int it = 0; it < 12; it++) begin
      m = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, 63));
      model(m, n, r, ov, ticks);
      start_run(m[1:0], n[5:0]);
      wait_done(0, cyc);
      checks++; if (result !== r[15:0] || overflow !== ov) begin failures++;
        $display("FAIL rand_result m=%0d n=%0d got=%0d ovf=%b exp=%0d ovf=%b", m, n, result, overflow, r, ov); end
      checks++; if (seg !== exp_seg(r, ov) || status_led !== {1'b1, ov}) begin failures++;
        $display("FAIL rand_disp m=%0d n=%0d got seg=%h led=%b exp seg=%h", m, n, seg, status_led, exp_seg(r, ov)); end
      checks++; if (cyc != ticks * 2 + 16) begin failures++;
        $display("FAIL rand_latency m=%0d n=%0d got=%0d exp=%0d", m, n, cyc, ticks * 2 + 16); end
    end
  endtask

  initial begin
    test_reset();
    test_sum10();
    test_fact_restart();
    test_overflow();
    test_zero();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
